// File: rtl/divide_vector_pkg.sv
// divide_vector_pkg: precision lookup, canonical special encodings, unpacked float and FSM types
package divide_vector_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, DIV, PACK, DONE} state_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] mant;
      logic        is_zero;
      logic        is_inf;
      logic        is_nan;
   } fp_t;

   localparam logic [15:0] QNAN_HALF   = 16'h7E00;
   localparam logic [15:0] INF_HALF    = 16'h7C00;
   localparam logic [31:0] QNAN_SINGLE = 32'h7FC0_0000;
   localparam logic [31:0] INF_SINGLE  = 32'h7F80_0000;

   function automatic int exp_bits(input bit single);
      return single ? 8 : 5;
   endfunction

   function automatic int mant_bits(input bit single);
      return single ? 23 : 10;
   endfunction

   function automatic int bias_of(input bit single);
      return single ? 127 : 15;
   endfunction

endpackage

// File: rtl/mant_divider.sv
// mant_divider: radix-2 restoring divider, quot = floor(dividend * 2^W / divisor) over W+1 cycles.
module mant_divider #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W:0]   quot
);

   localparam int CW = $clog2(W + 1);

   logic [W+1:0] rem_q, rem_d, diff;
   logic [W-1:0] dvs_q, dvs_d;
   logic [W:0]   quot_q, quot_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic         busy_q, busy_d, ge;

   always_comb begin
      ge     = rem_q >= {2'b00, dvs_q};
      diff   = ge ? rem_q - {2'b00, dvs_q} : rem_q;
      done   = busy_q && cnt_q == CW'(W);
      rem_d  = busy_q ? diff << 1 : rem_q;
      quot_d = busy_q ? {quot_q[W-1:0], ge} : quot_q;
      cnt_d  = busy_q ? cnt_q + 1'b1 : cnt_q;
      busy_d = busy_q && !done;
      dvs_d  = dvs_q;
      if (start) begin
         rem_d  = {2'b00, dividend};
         dvs_d  = divisor;
         quot_d = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rem_q  <= '0;
         dvs_q  <= '0;
         quot_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         quot_q <= quot_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign quot = quot_q;

endmodule

// File: rtl/divide_vector.sv
// divide_vector: element-wise IEEE-754 vector divider sharing one mantissa divider across N elements.
module divide_vector
   import divide_vector_pkg::*;
#(
   parameter int    BITS      = 16,
   parameter string PRECISION = "HALF",
   parameter int    N         = 3
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] a [N],
   input  logic [BITS-1:0] b [N],
   output logic            out_valid,
   output logic [BITS-1:0] c [N]
);

   localparam bit SGL  = PRECISION == "SINGLE";
   localparam int EXP  = exp_bits(SGL);
   localparam int MANT = mant_bits(SGL);
   localparam int BIAS = bias_of(SGL);
   localparam int IW   = N > 1 ? $clog2(N) : 1;
   localparam logic [31:0] QNAN_W = SGL ? QNAN_SINGLE : {16'h0000, QNAN_HALF};
   localparam logic [31:0] INF_W  = SGL ? INF_SINGLE : {16'h0000, INF_HALF};
   localparam logic [BITS-1:0] QNAN = QNAN_W[BITS-1:0];
   localparam logic [BITS-1:0] INF  = INF_W[BITS-1:0];

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [BITS-1:0] a_q [N], a_d [N], b_q [N], b_d [N], c_q [N], c_d [N];
   logic [BITS-1:0] res, szero;
   logic [MANT+1:0] quot;
   logic [MANT-1:0] frac;
   logic [EXP+1:0]  e;
   logic            start, done, sgn;
   fp_t             fa, fb;

   // Subnormals have a zero exponent and so fall into is_zero, which flushes them.
   function automatic fp_t unpack(input logic [BITS-1:0] w);
      fp_t             f;
      logic [EXP-1:0]  ew;
      logic [MANT-1:0] fw;
      ew        = w[BITS-2:MANT];
      fw        = w[MANT-1:0];
      f.sign    = w[BITS-1];
      f.exp     = 8'(ew);
      f.mant    = 24'({1'b1, fw});
      f.is_zero = ew == '0;
      f.is_inf  = &ew && fw == '0;
      f.is_nan  = &ew && fw != '0;
      return f;
   endfunction

   mant_divider #(.W(MANT + 1)) u_div (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .dividend ((MANT + 1)'(fa.mant)),
      .divisor  ((MANT + 1)'(fb.mant)),
      .done     (done),
      .quot     (quot)
   );

   always_comb begin
      fa    = unpack(a_q[idx_q]);
      fb    = unpack(b_q[idx_q]);
      sgn   = fa.sign ^ fb.sign;
      szero = {sgn, {(BITS-1){1'b0}}};
      frac  = quot[MANT+1] ? quot[MANT:1] : quot[MANT-1:0];
      e     = (EXP+2)'(fa.exp) - (EXP+2)'(fb.exp) + (EXP+2)'(BIAS) - (EXP+2)'(!quot[MANT+1]);
      res   = (fa.is_nan || fb.is_nan || (fa.is_zero && fb.is_zero) || (fa.is_inf && fb.is_inf)) ? QNAN
            : (fa.is_inf || fb.is_zero) ? (INF | szero)
            : (fa.is_zero || fb.is_inf) ? szero
            : (!e[EXP+1] && e[EXP:0] >= (EXP+1)'((1 << EXP) - 1)) ? (INF | szero)
            : (e[EXP+1] || e == '0) ? szero
            : {sgn, e[EXP-1:0], frac};
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      start   = 1'b0;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = a;
            b_d     = b;
            idx_d   = '0;
            state_d = LOAD;
         end
         LOAD: begin
            start   = 1'b1;
            state_d = DIV;
         end
         DIV: if (done) state_d = PACK;
         PACK: begin
            c_d[idx_q] = res;
            idx_d      = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
            state_d    = (idx_q == IW'(N - 1)) ? DONE : LOAD;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         c_q     <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
      end
   end

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign c         = c_q;

endmodule

// File: tb/tb_divide_vector.sv
// tb_divide_vector: scoreboard bench for a HALF N=3 and a SINGLE N=1 divide_vector instance.
module tb_divide_vector;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic        iv_h, ir_h, ov_h;
   logic [15:0] a_h [3], b_h [3], c_h [3];
   logic        iv_s, ir_s, ov_s;
   logic [31:0] a_s [1], b_s [1], c_s [1];

   int          n_chk = 0, n_err = 0, cyc = 0, acc_last = 0, acc_prev = 0;
   logic [47:0] sb_h [$];
   logic [31:0] sb_s [$];
   int          acc_h [$], acc_s [$];
   logic [47:0] eh;
   logic [31:0] es;

   divide_vector #(.BITS(16), .PRECISION("HALF"), .N(3)) dut_h (
      .clk(clk), .rstn(rstn), .in_valid(iv_h), .in_ready(ir_h),
      .a(a_h), .b(b_h), .out_valid(ov_h), .c(c_h)
   );

   divide_vector #(.BITS(32), .PRECISION("SINGLE"), .N(1)) dut_s (
      .clk(clk), .rstn(rstn), .in_valid(iv_s), .in_ready(ir_s),
      .a(a_s), .b(b_s), .out_valid(ov_s), .c(c_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rstn && iv_h && ir_h) begin
         acc_h.push_back(cyc);
         acc_prev <= acc_last;
         acc_last <= cyc;
      end
      if (rstn && iv_s && ir_s) acc_s.push_back(cyc);
   end

   always @(negedge clk) begin
      if (ov_h) begin
         chk("sb_h_avail", 32'(sb_h.size() > 0 && acc_h.size() > 0), 1);
         if (sb_h.size() > 0 && acc_h.size() > 0) begin
            eh = sb_h.pop_front();
            chk("c_h0", 32'(c_h[0]), 32'(eh[15:0]));
            chk("c_h1", 32'(c_h[1]), 32'(eh[31:16]));
            chk("c_h2", 32'(c_h[2]), 32'(eh[47:32]));
            chk("lat_h", cyc - acc_h.pop_front(), 43);
         end
      end
      if (ov_s) begin
         chk("sb_s_avail", 32'(sb_s.size() > 0 && acc_s.size() > 0), 1);
         if (sb_s.size() > 0 && acc_s.size() > 0) begin
            es = sb_s.pop_front();
            chk("c_s0", c_s[0], es);
            chk("lat_s", cyc - acc_s.pop_front(), 28);
         end
      end
   end

   task automatic send_h(input logic [47:0] av, input logic [47:0] bv, input logic [47:0] ev);
      @(negedge clk);
      chk("rdy_h_idle", 32'(ir_h), 1);
      {a_h[2], a_h[1], a_h[0]} = av;
      {b_h[2], b_h[1], b_h[0]} = bv;
      iv_h = 1'b1;
      sb_h.push_back(ev);
      @(negedge clk);
      iv_h = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_h[k] = 16'($urandom);
         b_h[k] = 16'($urandom);
      end
   endtask

   task automatic wait_h(input int lim);
      int k = 0;
      while (!ov_h && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk("ov_h_seen", 32'(ov_h), 1);
      @(negedge clk);
      chk("ov_h_pulse", 32'(ov_h), 0);
      chk("rdy_h_back", 32'(ir_h), 1);
   endtask

   task automatic run_h(input logic [47:0] av, input logic [47:0] bv, input logic [47:0] ev);
      send_h(av, bv, ev);
      wait_h(60);
   endtask

   task automatic run_s(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev);
      int k = 0;
      @(negedge clk);
      a_s[0] = av;
      b_s[0] = bv;
      iv_s   = 1'b1;
      sb_s.push_back(ev);
      @(negedge clk);
      iv_s   = 1'b0;
      a_s[0] = $urandom;
      b_s[0] = $urandom;
      while (!ov_s && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("ov_s_seen", 32'(ov_s), 1);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      rstn = 1'b0;
      iv_h = 1'b0;
      iv_s = 1'b0;
      a_h  = '{default: '0};
      b_h  = '{default: '0};
      a_s  = '{default: '0};
      b_s  = '{default: '0};
      repeat (2) @(negedge clk);
      chk("rst_rdy_h", 32'(ir_h), 1);
      chk("rst_ov_h", 32'(ov_h), 0);
      for (int k = 0; k < 3; k++) chk("rst_c_h", 32'(c_h[k]), 0);
      chk("rst_rdy_s", 32'(ir_s), 1);
      chk("rst_c_s", c_s[0], 0);
      rstn = 1'b1;

      run_h({16'hBC00, 16'h3C00, 16'h4600}, {16'h4400, 16'h4200, 16'h4000}, {16'hB400, 16'h3555, 16'h4200});
      run_h({16'h7C00, 16'h0000, 16'h3C00}, {16'h7C00, 16'h0000, 16'h0000}, {16'h7E00, 16'h7E00, 16'h7C00});
      run_h({16'h8400, 16'h0400, 16'h7BFF}, {16'h4400, 16'h4400, 16'h3800}, {16'h8000, 16'h0000, 16'h7C00});
      run_h({16'hFC00, 16'h3C00, 16'h7E01}, {16'h3C00, 16'hFC00, 16'h3C00}, {16'hFC00, 16'h8000, 16'h7E00});
      run_h({16'hC000, 16'h3C00, 16'h0001}, {16'hC000, 16'h0200, 16'h3C00}, {16'h3C00, 16'h7C00, 16'h0000});

      // in_valid held high across a whole vector; busy-time operands must be dropped
      @(negedge clk);
      {a_h[2], a_h[1], a_h[0]} = {16'hBC00, 16'h3C00, 16'h4600};
      {b_h[2], b_h[1], b_h[0]} = {16'h4400, 16'h4200, 16'h4000};
      iv_h = 1'b1;
      sb_h.push_back({16'hB400, 16'h3555, 16'h4200});
      @(negedge clk);
      a_h = '{default: 16'h4000};
      b_h = '{default: 16'h4000};
      repeat (10) @(negedge clk);
      chk("busy_rdy_h", 32'(ir_h), 0);
      cnt = 0;
      while (!ov_h && cnt < 60) begin
         @(negedge clk);
         cnt++;
      end
      chk("hs_ov_seen", 32'(ov_h), 1);
      {a_h[2], a_h[1], a_h[0]} = {16'h8400, 16'h0400, 16'h7BFF};
      {b_h[2], b_h[1], b_h[0]} = {16'h4400, 16'h4400, 16'h3800};
      sb_h.push_back({16'h8000, 16'h0000, 16'h7C00});
      @(negedge clk);
      @(negedge clk);
      iv_h = 1'b0;
      wait_h(60);
      chk("spacing_h", acc_last - acc_prev, 44);

      // abort a vector with reset partway through
      send_h({16'hBC00, 16'h3C00, 16'h4600}, {16'h4400, 16'h4200, 16'h4000}, {16'hB400, 16'h3555, 16'h4200});
      repeat (19) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("abort_ov_h", 32'(ov_h), 0);
      chk("abort_rdy_h", 32'(ir_h), 1);
      for (int k = 0; k < 3; k++) chk("abort_c_h", 32'(c_h[k]), 0);
      sb_h.delete();
      acc_h.delete();
      rstn = 1'b1;
      cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (ov_h) cnt++;
      end
      chk("abort_no_ov", cnt, 0);
      run_h({16'hBC00, 16'h3C00, 16'h4600}, {16'h4400, 16'h4200, 16'h4000}, {16'hB400, 16'h3555, 16'h4200});

      run_s(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
      run_s(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);

      repeat (3) @(negedge clk);
      chk("sb_h_drained", sb_h.size(), 0);
      chk("sb_s_drained", sb_s.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
